// File: rtl/cam_bram_pkg.sv
// Shared constants and width helpers for the RAM-based CAM/TCAM engine.
package cam_bram_pkg;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT   = 3'd0;
    localparam state_t ST_IDLE   = 3'd1;
    localparam state_t ST_UPD_RD = 3'd2;
    localparam state_t ST_UPD_WR = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int slice_num(input int key_width, input int slice_width);
        return key_width / slice_width;
    endfunction

    function automatic int idx_width(input int entry_num);
        return (entry_num > 1) ? clog2(entry_num) : 1;
    endfunction

endpackage

// File: rtl/cam_bram_if.sv
// Lookup, result and update signals of the CAM engine, plus FSM state visibility.
interface cam_bram_if #(
    parameter int KEY_WIDTH = 32,
    parameter int ENTRY_NUM = 64,
    parameter int IDX_W     = cam_bram_pkg::idx_width(ENTRY_NUM)
);
    // Handshake: a request transfers on a rising clk edge where valid && ready;
    // the requester holds valid and payload stable until then. Results and
    // update completion are single-cycle strobes with no back-pressure.
    logic                 i_lkp_valid;
    logic                 o_lkp_ready;
    logic [KEY_WIDTH-1:0] i_lkp_key;
    logic                 o_res_valid;
    logic                 o_res_hit;
    logic [IDX_W-1:0]     o_res_idx;
    logic [ENTRY_NUM-1:0] o_res_vec;
    logic                 i_upd_valid;
    logic                 o_upd_ready;
    logic                 i_upd_op;
    logic [IDX_W-1:0]     i_upd_idx;
    logic [KEY_WIDTH-1:0] i_upd_key;
    logic [KEY_WIDTH-1:0] i_upd_mask;
    logic                 o_upd_done;
    logic                 o_upd_err;
    logic                 o_init_done;
    logic [2:0]           dbg_state;

    modport master (
        output i_lkp_valid, i_lkp_key, i_upd_valid, i_upd_op, i_upd_idx, i_upd_key, i_upd_mask,
        input  o_lkp_ready, o_res_valid, o_res_hit, o_res_idx, o_res_vec,
               o_upd_ready, o_upd_done, o_upd_err, o_init_done, dbg_state
    );

    modport slave (
        input  i_lkp_valid, i_lkp_key, i_upd_valid, i_upd_op, i_upd_idx, i_upd_key, i_upd_mask,
        output o_lkp_ready, o_res_valid, o_res_hit, o_res_idx, o_res_vec,
               o_upd_ready, o_upd_done, o_upd_err, o_init_done, dbg_state
    );

endinterface

// File: rtl/cam_bram_slice.sv
// One key slice: simple dual-port RAM, DEPTH x ENTRY_NUM, write port A, registered read port B.
module cam_bram_slice #(
    parameter int SLICE_WIDTH = 4,
    parameter int ENTRY_NUM   = 64
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [SLICE_WIDTH-1:0] wr_addr,
    input  logic [ENTRY_NUM-1:0]   wr_data,
    input  logic [SLICE_WIDTH-1:0] rd_addr,
    output logic [ENTRY_NUM-1:0]   rd_data
);
    localparam int DEPTH = 1 << SLICE_WIDTH;

    logic [ENTRY_NUM-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cam_bram_engine.sv
// RAM-based CAM/TCAM: per-slice match vectors ANDed and priority-encoded on lookup,
// read-modify-write sweeps for updates and a clear sweep after reset.
module cam_bram_engine
    import cam_bram_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int SLICE_WIDTH = 4,
    parameter int ENTRY_NUM   = 64,
    parameter int TCAM_MODE   = 0
) (
    input logic       i_clk,
    input logic       i_rst,
    cam_bram_if.slave bus
);
    localparam int SLICE_NUM = slice_num(KEY_WIDTH, SLICE_WIDTH);
    localparam int IDX_W     = idx_width(ENTRY_NUM);
    localparam int DEPTH     = 1 << SLICE_WIDTH;
    localparam logic [SLICE_WIDTH-1:0] LAST_ADDR = SLICE_WIDTH'(DEPTH - 1);
    localparam logic [IDX_W:0]         ENTRY_LIM = (IDX_W + 1)'(ENTRY_NUM);

    state_t                 state;
    logic [SLICE_WIDTH-1:0] addr;
    logic                   init_done;
    logic                   upd_done, upd_err, err_pend;
    logic                   upd_op_q;
    logic [IDX_W-1:0]       upd_idx_q;
    logic [KEY_WIDTH-1:0]   upd_key_q, upd_mask_q;

    logic [KEY_WIDTH-1:0]   lkp_key_q;
    logic                   v1, v2, v3;
    logic [ENTRY_NUM-1:0]   and_q, and_all;
    logic                   res_valid, res_hit;
    logic [IDX_W-1:0]       res_idx;
    logic [ENTRY_NUM-1:0]   res_vec;

    logic [ENTRY_NUM-1:0]   rd_word [SLICE_NUM];
    logic                   lkp_acc, upd_acc, upd_ready, ram_we;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [ENTRY_NUM-1:0] v);
        lowest_set = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign upd_ready = (state == ST_IDLE) && !(v1 || v2 || v3) && !bus.i_lkp_valid;
    assign lkp_acc   = bus.i_lkp_valid && (state == ST_IDLE);
    assign upd_acc   = bus.i_upd_valid && upd_ready;
    assign ram_we    = (state == ST_INIT) || (state == ST_UPD_WR);

    // Every slice is written at the same sweep address; only its data word differs.
    for (genvar s = 0; s < SLICE_NUM; s++) begin : g_slice
        logic [SLICE_WIDTH-1:0] key_s, mask_s, rd_addr;
        logic [ENTRY_NUM-1:0]   wr_word;

        assign key_s   = upd_key_q[s*SLICE_WIDTH +: SLICE_WIDTH];
        assign mask_s  = upd_mask_q[s*SLICE_WIDTH +: SLICE_WIDTH];
        assign rd_addr = (state == ST_UPD_RD) ? addr : lkp_key_q[s*SLICE_WIDTH +: SLICE_WIDTH];

        always_comb begin
            wr_word = rd_word[s];
            wr_word[upd_idx_q] = (upd_op_q == OP_DELETE) ? 1'b0
                               : (((addr ^ key_s) & ~mask_s) == '0);
            if (state == ST_INIT) wr_word = '0;
        end

        cam_bram_slice #(.SLICE_WIDTH(SLICE_WIDTH), .ENTRY_NUM(ENTRY_NUM)) u_slice (
            .clk     (i_clk),
            .we      (ram_we),
            .wr_addr (addr),
            .wr_data (wr_word),
            .rd_addr (rd_addr),
            .rd_data (rd_word[s])
        );
    end

    always_comb begin
        and_all = '1;
        for (int s = 0; s < SLICE_NUM; s++) and_all = and_all & rd_word[s];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_INIT;
            addr       <= '0;
            init_done  <= 1'b0;
            upd_done   <= 1'b0;
            upd_err    <= 1'b0;
            err_pend   <= 1'b0;
            upd_op_q   <= OP_WRITE;
            upd_idx_q  <= '0;
            upd_key_q  <= '0;
            upd_mask_q <= '0;
        end else begin
            upd_done <= 1'b0;
            upd_err  <= 1'b0;
            case (state)
                ST_INIT: begin
                    addr <= addr + 1'b1;
                    if (addr == LAST_ADDR) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (upd_acc) begin
                        upd_op_q   <= bus.i_upd_op;
                        upd_idx_q  <= bus.i_upd_idx;
                        upd_key_q  <= bus.i_upd_key;
                        upd_mask_q <= (TCAM_MODE != 0) ? bus.i_upd_mask : '0;
                        addr       <= '0;
                        err_pend   <= ({1'b0, bus.i_upd_idx} >= ENTRY_LIM);
                        state      <= ({1'b0, bus.i_upd_idx} >= ENTRY_LIM) ? ST_DONE : ST_UPD_RD;
                    end
                end
                ST_UPD_RD: state <= ST_UPD_WR;
                ST_UPD_WR: begin
                    addr  <= addr + 1'b1;
                    state <= (addr == LAST_ADDR) ? ST_DONE : ST_UPD_RD;
                end
                ST_DONE: begin
                    upd_done <= 1'b1;
                    upd_err  <= err_pend;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lookup pipeline: key register, RAM read, AND register, encoded result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lkp_key_q <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            and_q     <= '0;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_vec   <= '0;
        end else begin
            v1 <= lkp_acc;
            if (lkp_acc) lkp_key_q <= bus.i_lkp_key;
            v2        <= v1;
            v3        <= v2;
            and_q     <= and_all;
            res_valid <= v3;
            if (v3) begin
                res_hit <= |and_q;
                res_idx <= lowest_set(and_q);
                res_vec <= and_q;
            end
        end
    end

    assign bus.o_lkp_ready = (state == ST_IDLE);
    assign bus.o_upd_ready = upd_ready;
    assign bus.o_res_valid = res_valid;
    assign bus.o_res_hit   = res_hit;
    assign bus.o_res_idx   = res_idx;
    assign bus.o_res_vec   = res_vec;
    assign bus.o_upd_done  = upd_done;
    assign bus.o_upd_err   = upd_err;
    assign bus.o_init_done = init_done;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_cam_bram_engine.sv
// Bench for cam_bram_engine: an exact-match 64-entry instance and a ternary 48-entry instance.
module tb_cam_bram_engine;
    import cam_bram_pkg::*;

    localparam int W = 103;  // {expected cycle[31:0], hit, idx[5:0], vec[63:0]}

    logic clk, rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];

    logic [31:0] m_key  [2][64];
    logic [31:0] m_mask [2][64];
    bit          m_used [2][64];

    cam_bram_if #(.KEY_WIDTH(32), .ENTRY_NUM(64)) a_if ();
    cam_bram_if #(.KEY_WIDTH(32), .ENTRY_NUM(48)) b_if ();

    cam_bram_engine #(.KEY_WIDTH(32), .SLICE_WIDTH(4), .ENTRY_NUM(64), .TCAM_MODE(0)) dut_a (
        .i_clk (clk), .i_rst (rst), .bus (a_if)
    );
    cam_bram_engine #(.KEY_WIDTH(32), .SLICE_WIDTH(4), .ENTRY_NUM(48), .TCAM_MODE(1)) dut_b (
        .i_clk (clk), .i_rst (rst), .bus (b_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: whole-key ternary compare against every stored entry
    function automatic logic [70:0] model_lookup(input int d, input logic [31:0] k);
        logic [63:0] v;
        logic [5:0]  ix;
        logic        h;
        int          lim;
        v   = '0;
        ix  = '0;
        h   = 1'b0;
        lim = (d == 0) ? 64 : 48;
        for (int e = 0; e < lim; e++)
            if (m_used[d][e] && (((k ^ m_key[d][e]) & ~m_mask[d][e]) == 32'h0)) v[e] = 1'b1;
        for (int e = lim - 1; e >= 0; e--)
            if (v[e]) begin ix = 6'(e); h = 1'b1; end
        return {h, ix, v};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 64; e++) begin
                m_used[d][e] = 1'b0;
                m_key[d][e]  = '0;
                m_mask[d][e] = '0;
            end
    endtask

    // driver tasks
    function automatic logic lkp_rdy(input int d);
        return (d == 0) ? a_if.o_lkp_ready : b_if.o_lkp_ready;
    endfunction
    function automatic logic upd_rdy(input int d);
        return (d == 0) ? a_if.o_upd_ready : b_if.o_upd_ready;
    endfunction
    function automatic logic done_of(input int d);
        return (d == 0) ? a_if.o_upd_done : b_if.o_upd_done;
    endfunction
    function automatic logic err_of(input int d);
        return (d == 0) ? a_if.o_upd_err : b_if.o_upd_err;
    endfunction

    task automatic drive_lkp(input int d, input logic v, input logic [31:0] k);
        if (d == 0) begin a_if.i_lkp_valid = v; a_if.i_lkp_key = k; end
        else        begin b_if.i_lkp_valid = v; b_if.i_lkp_key = k; end
    endtask

    task automatic drive_upd(input int d, input logic v, input logic op, input logic [5:0] idx,
                             input logic [31:0] key, input logic [31:0] mask);
        if (d == 0) begin
            a_if.i_upd_valid = v; a_if.i_upd_op = op; a_if.i_upd_idx = idx;
            a_if.i_upd_key = key; a_if.i_upd_mask = mask;
        end else begin
            b_if.i_upd_valid = v; b_if.i_upd_op = op; b_if.i_upd_idx = idx;
            b_if.i_upd_key = key; b_if.i_upd_mask = mask;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic lkp(input int d, input logic [31:0] key, input bit last, output int acc);
        int n = 0;
        drive_lkp(d, 1'b1, key);
        while (!lkp_rdy(d) && n < 500) begin @(negedge clk); n++; end
        chk("lkp_accept", lkp_rdy(d), 1);
        acc = cyc + 1;
        if (d == 0) exp_qa.push_back({32'(acc + 3), model_lookup(d, key)});
        else        exp_qb.push_back({32'(acc + 3), model_lookup(d, key)});
        @(negedge clk);
        if (last) drive_lkp(d, 1'b0, key);
    endtask

    task automatic upd_begin(input int d, input logic op, input logic [5:0] idx,
                             input logic [31:0] key, input logic [31:0] mask, output int acc);
        int n = 0;
        drive_upd(d, 1'b1, op, idx, key, mask);
        while (!upd_rdy(d) && n < 500) begin @(negedge clk); n++; end
        chk("upd_accept", upd_rdy(d), 1);
        acc = cyc + 1;
        @(negedge clk);
        drive_upd(d, 1'b0, op, idx, key, mask);
    endtask

    task automatic upd_end(input int d, input int acc, input logic op, input logic [5:0] idx,
                           input logic [31:0] key, input logic [31:0] mask, input logic exp_err);
        int n = 0;
        while (!done_of(d) && n < 200) begin @(negedge clk); n++; end
        chk("upd_done", done_of(d), 1);
        chk("upd_latency", cyc - acc, exp_err ? 1 : 33);
        chk("upd_err", err_of(d), exp_err);
        if (!exp_err) begin
            m_used[d][idx] = (op == OP_WRITE);
            m_key[d][idx]  = key;
            m_mask[d][idx] = (d == 0) ? 32'h0 : mask;
        end
    endtask

    task automatic upd(input int d, input logic op, input logic [5:0] idx,
                       input logic [31:0] key, input logic [31:0] mask, input logic exp_err);
        int acc;
        upd_begin(d, op, idx, key, mask, acc);
        upd_end(d, acc, op, idx, key, mask, exp_err);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_init_done", a_if.o_init_done, 0);
        chk("rst_res_valid", a_if.o_res_valid, 0);
        chk("rst_res_hit",   a_if.o_res_hit, 0);
        chk("rst_res_idx",   a_if.o_res_idx, 0);
        chk("rst_res_vec",   a_if.o_res_vec, 0);
        chk("rst_upd_done",  a_if.o_upd_done, 0);
        chk("rst_upd_err",   a_if.o_upd_err, 0);
        chk("rst_lkp_ready", a_if.o_lkp_ready, 0);
        chk("rst_upd_ready", a_if.o_upd_ready, 0);
        chk("rst_state",     a_if.dbg_state, ST_INIT);
        chk("rst_b_init",    b_if.o_init_done, 0);
    endtask

    task automatic wait_init();
        int n = 0;
        do begin @(negedge clk); n++; end while (!a_if.o_init_done && n < 100);
        chk("init_latency", n, 16);
        chk("init_b_done", b_if.o_init_done, 1);
        chk("init_state_idle", a_if.dbg_state, ST_IDLE);
    endtask

    // scoreboard: compare every result strobe against the head of the expected queue
    task automatic check_res(input int d, input logic [70:0] got);
        logic [W-1:0] e;
        int pend;
        pend = (d == 0) ? exp_qa.size() : exp_qb.size();
        chk((d == 0) ? "a_res_pending" : "b_res_pending", pend > 0, 1);
        if (pend > 0) begin
            e = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
            chk("res_cycle", cyc, e[102:71]);
            chk("res_hit", got[70], e[70]);
            chk("res_idx", got[69:64], e[69:64]);
            chk("res_vec", got[63:0], e[63:0]);
        end
    endtask

    always @(negedge clk) begin
        if (a_if.o_res_valid) check_res(0, {a_if.o_res_hit, a_if.o_res_idx, a_if.o_res_vec});
        if (b_if.o_res_valid) check_res(1, {b_if.o_res_hit, b_if.o_res_idx, 16'h0, b_if.o_res_vec});
    end

    initial begin
        int t, t_l, t_u;
        model_clear();
        rst = 1'b1;
        drive_lkp(0, 1'b0, '0);
        drive_lkp(1, 1'b0, '0);
        drive_upd(0, 1'b0, OP_WRITE, '0, '0, '0);
        drive_upd(1, 1'b0, OP_WRITE, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        wait_init();

        // empty table
        lkp(0, 32'h0, 1, t);
        lkp(1, $urandom_range(0, 32'hFFFF), 1, t);

        // exact match on the 64-entry CAM
        upd(0, OP_WRITE, 6'd5, 32'h12345678, 32'h0, 1'b0);
        lkp(0, 32'h12345678, 0, t);
        lkp(0, 32'h12345679, 1, t);
        upd(0, OP_WRITE, 6'd9, 32'hAABBCCDD, 32'h0, 1'b0);
        upd(0, OP_WRITE, 6'd3, 32'hAABBCCDD, 32'h0, 1'b0);
        lkp(0, 32'hAABBCCDD, 1, t);
        upd(0, OP_DELETE, 6'd3, 32'h0, 32'h0, 1'b0);
        lkp(0, 32'hAABBCCDD, 1, t);
        upd(0, OP_WRITE, 6'd5, 32'hAABBCCDD, 32'h0, 1'b0);
        lkp(0, 32'h12345678, 0, t);
        lkp(0, 32'hAABBCCDD, 1, t);
        upd(0, OP_DELETE, 6'd20, 32'h0, 32'h0, 1'b0);
        upd(0, OP_WRITE, 6'd7, 32'h000000F0, 32'h0000000F, 1'b0);
        lkp(0, 32'h000000F7, 0, t);
        lkp(0, 32'h000000F0, 1, t);

        // simultaneous requests: lookup first, update later
        drive_upd(0, 1'b1, OP_WRITE, 6'd12, 32'hCAFEF00D, 32'h0);
        drive_lkp(0, 1'b1, 32'hAABBCCDD);
        #1;
        chk("upd_blocked_by_lkp", a_if.o_upd_ready, 0);
        lkp(0, 32'hAABBCCDD, 1, t_l);
        upd_begin(0, OP_WRITE, 6'd12, 32'hCAFEF00D, 32'h0, t_u);
        chk("lkp_before_upd", t_u > t_l + 2, 1);
        upd_end(0, t_u, OP_WRITE, 6'd12, 32'hCAFEF00D, 32'h0, 1'b0);
        lkp(0, 32'hCAFEF00D, 1, t);

        // ternary 48-entry instance
        upd(1, OP_WRITE, 6'd0, 32'h000000F0, 32'h0000000F, 1'b0);
        lkp(1, 32'h000000F7, 0, t);
        lkp(1, 32'h000000F0, 0, t);
        lkp(1, 32'h000000E0, 1, t);
        upd(1, OP_WRITE, 6'd0, 32'h11111111, 32'h0, 1'b0);
        lkp(1, 32'h000000F0, 0, t);
        lkp(1, 32'h11111111, 0, t);
        lkp(1, 32'h11111110, 1, t);
        upd(1, OP_WRITE, 6'd47, 32'h00000055, 32'h0, 1'b0);
        lkp(1, 32'h00000055, 1, t);
        upd(1, OP_WRITE, 6'd48, 32'h00000077, 32'h0, 1'b1);
        upd(1, OP_WRITE, 6'd50, 32'h11111111, 32'h0, 1'b1);
        lkp(1, 32'h11111111, 0, t);
        lkp(1, 32'h00000077, 1, t);

        // reset in the middle of an update sweep
        upd_begin(0, OP_WRITE, 6'd11, 32'h0BADBEEF, 32'h0, t);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        wait_init();
        lkp(0, 32'hAABBCCDD, 0, t);
        lkp(0, 32'h0BADBEEF, 0, t);
        lkp(0, 32'hCAFEF00D, 1, t);
        lkp(1, 32'h11111111, 1, t);

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", exp_qa.size() + exp_qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
